// File: rtl/result_writeback_buffer_pkg.sv
// rtl/result_writeback_buffer_pkg.sv - shared types and defaults for the result writeback buffer
package result_writeback_buffer_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/result_writeback_buffer_if.sv
// rtl/result_writeback_buffer_if.sv - job control, input stream and memory write signals
interface result_writeback_buffer_if
  import result_writeback_buffer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    length;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wr_data;
  logic                mem_ready;
  logic                busy;
  logic                done;
  logic                drop_err;

  modport master (
    output start, base_addr, length, in_valid, in_data, mem_ready,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, busy, done, drop_err
  );

  modport slave (
    input  start, base_addr, length, in_valid, in_data, mem_ready,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, busy, done, drop_err
  );

endinterface

// File: rtl/result_writeback_buffer_sync_fifo.sv
// rtl/result_writeback_buffer_sync_fifo.sv - first-word-fall-through synchronous FIFO
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/result_writeback_buffer.sv
// rtl/result_writeback_buffer.sv - buffers fused results and writes them to sequential word addresses
module result_writeback_buffer
  import result_writeback_buffer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  result_writeback_buffer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   wr_q, wr_d;
  logic               drop_q, drop_d;

  logic               full, empty, push, pop;
  logic               in_ready, mem_wr_en;
  logic [DATA_W-1:0]  rdata;

  // Ready ignores a same-cycle pop so the full check never depends on mem_ready.
  assign in_ready  = !rst && (state_q == ST_RUN) && !full && (acc_q < len_q);
  assign mem_wr_en = !rst && !empty;
  assign push      = bus.in_valid && in_ready;
  assign pop       = mem_wr_en && bus.mem_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    drop_d  = drop_q | (bus.in_valid && (state_q != ST_RUN));
    if (push) acc_d = acc_q + CNT_ONE;
    if (pop)  wr_d  = wr_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          base_d  = bus.base_addr;
          len_d   = bus.length;
          acc_d   = '0;
          wr_d    = '0;
          state_d = (bus.length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (pop && (wr_d == len_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_addr    = rst ? '0 : base_q + ADDR_W'(wr_q);
  assign bus.mem_wr_data = (rst || empty) ? '0 : rdata;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.drop_err    = drop_q;

endmodule

// File: tb/tb_result_writeback_buffer.sv
// tb/tb_result_writeback_buffer.sv - self-checking bench for result_writeback_buffer
module tb_result_writeback_buffer;

  logic clk;
  logic rst;

  result_writeback_buffer_if #(.ADDR_W(16)) bus ();

  result_writeback_buffer #(
    .DEPTH  (8),
    .ADDR_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int n_checks = 0;

  // Reference model: job mode, counters, and the buffered words as a queue.
  int          m_mode;
  int          m_acc, m_wr, m_len;
  logic [15:0] m_base;
  logic [31:0] m_q[$];
  bit          m_drop;

  logic [15:0] wlog_addr[$];
  logic [31:0] wlog_data[$];
  int          acc_seen  = 0;
  int          done_cnt  = 0;
  int          busy_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    int          sz;
    bit          e_ready, push, pop;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    if (rst) begin
      m_mode = 0; m_q.delete(); m_acc = 0; m_wr = 0; m_len = 0; m_base = '0; m_drop = 1'b0;
    end else begin
      sz      = m_q.size();
      e_ready = (m_mode == 1) && (sz < 8) && (m_acc < m_len);
      e_addr  = m_base + 16'(m_wr);
      e_data  = (sz > 0) ? m_q[0] : 32'h0;
      chk("in_ready",    32'(bus.in_ready),    32'(e_ready));
      chk("mem_wr_en",   32'(bus.mem_wr_en),   32'(sz > 0));
      chk("mem_addr",    32'(bus.mem_addr),    32'(e_addr));
      chk("mem_wr_data", bus.mem_wr_data,      e_data);
      chk("busy",        32'(bus.busy),        32'(m_mode != 0));
      chk("done",        32'(bus.done),        32'(m_mode == 2));
      chk("drop_err",    32'(bus.drop_err),    32'(m_drop));
      if (bus.mem_wr_en && bus.mem_ready) begin
        wlog_addr.push_back(bus.mem_addr);
        wlog_data.push_back(bus.mem_wr_data);
      end
      if (bus.in_valid && bus.in_ready) acc_seen++;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
      push = bus.in_valid && e_ready;
      pop  = (sz > 0) && bus.mem_ready;
      if (bus.in_valid && m_mode != 1) m_drop = 1'b1;
      case (m_mode)
        0: if (bus.start) begin
             m_base = bus.base_addr; m_len = int'(bus.length); m_acc = 0; m_wr = 0;
             m_mode = (bus.length == 16'd0) ? 2 : 1;
           end
        1: if (pop && (m_wr + 1 == m_len)) m_mode = 2;
        default: m_mode = 0;
      endcase
      if (pop)  begin void'(m_q.pop_front()); m_wr++; end
      if (push) begin m_q.push_back(bus.in_data); m_acc++; end
    end
  endtask

  task automatic cyc();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [15:0] len);
    bus.start = 1'b1; bus.base_addr = base; bus.length = len;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.busy && n < limit) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 32'(bus.busy), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},    32'(bus.in_ready),  32'h0);
    chk({tag, "_mem_wr_en"},   32'(bus.mem_wr_en), 32'h0);
    chk({tag, "_mem_addr"},    32'(bus.mem_addr),  32'h0);
    chk({tag, "_mem_wr_data"}, bus.mem_wr_data,    32'h0);
    chk({tag, "_busy"},        32'(bus.busy),      32'h0);
    chk({tag, "_done"},        32'(bus.done),      32'h0);
    chk({tag, "_drop_err"},    32'(bus.drop_err),  32'h0);
  endtask

  initial begin
    int mark_w, mark_a, mark_d, mark_b;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Four back-to-back words at 0x0100
    mark_w = wlog_addr.size(); mark_d = done_cnt;
    bus.mem_ready = 1'b1;
    start_job(16'h0100, 16'd4);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h11 * 32'(i + 1);
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("t1_ready_after4", 32'(bus.in_ready), 32'h0);
    wait_idle(20);
    chk("t1_nwrites", 32'(wlog_addr.size() - mark_w), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (mark_w + i < wlog_addr.size()) begin
        chk("t1_addr", 32'(wlog_addr[mark_w + i]), 32'h0100 + 32'(i));
        chk("t1_data", wlog_data[mark_w + i], 32'h11 * 32'(i + 1));
      end
    end
    chk("t1_done_once", 32'(done_cnt - mark_d), 32'd1);

    // Memory stalled while the producer keeps offering twelve words
    mark_w = wlog_addr.size(); mark_a = acc_seen;
    bus.mem_ready = 1'b0;
    start_job(16'h0000, 16'd12);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hA00 + 32'(acc_seen - mark_a);
      cyc();
    end
    chk("t2_accepted_stalled", 32'(acc_seen - mark_a), 32'd8);
    chk("t2_ready_full", 32'(bus.in_ready), 32'h0);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 40 && (acc_seen - mark_a) < 12; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hA00 + 32'(acc_seen - mark_a);
      cyc();
    end
    bus.in_valid = 1'b0;
    wait_idle(40);
    chk("t2_nwrites", 32'(wlog_addr.size() - mark_w), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (mark_w + i < wlog_addr.size()) begin
        chk("t2_addr", 32'(wlog_addr[mark_w + i]), 32'(i));
        chk("t2_data", wlog_data[mark_w + i], 32'hA00 + 32'(i));
      end
    end

    // Address wrap at the top of the space
    mark_w = wlog_addr.size();
    start_job(16'hFFFE, 16'd3);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hC0 + 32'(i);
      cyc();
    end
    bus.in_valid = 1'b0;
    wait_idle(20);
    chk("t3_nwrites", 32'(wlog_addr.size() - mark_w), 32'd3);
    if (wlog_addr.size() >= mark_w + 3) begin
      chk("t3_addr0", 32'(wlog_addr[mark_w]),     32'h0000FFFE);
      chk("t3_addr1", 32'(wlog_addr[mark_w + 1]), 32'h0000FFFF);
      chk("t3_addr2", 32'(wlog_addr[mark_w + 2]), 32'h00000000);
    end

    // Zero-length job
    mark_w = wlog_addr.size(); mark_d = done_cnt; mark_b = busy_cnt;
    start_job(16'h0040, 16'd0);
    wait_idle(5);
    cyc();
    chk("t4_busy_cycles", 32'(busy_cnt - mark_b), 32'd1);
    chk("t4_done_cycles", 32'(done_cnt - mark_d), 32'd1);
    chk("t4_nwrites", 32'(wlog_addr.size() - mark_w), 32'd0);

    // Word offered while idle is dropped and flagged
    mark_w = wlog_addr.size();
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD;
    cyc();
    bus.in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_drop_err", 32'(bus.drop_err), 32'h1);
    chk("t5_nwrites", 32'(wlog_addr.size() - mark_w), 32'd0);

    // Reset in the middle of a five-word job, then a fresh job
    mark_w = wlog_addr.size(); mark_a = acc_seen; mark_d = done_cnt;
    start_job(16'h0200, 16'd5);
    for (int i = 0; i < 20 && (wlog_addr.size() - mark_w) < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h50 + 32'(acc_seen - mark_a);
      cyc();
    end
    chk("t6_drop_still_set", 32'(bus.drop_err), 32'h1);
    rst = 1'b1;
    cyc();
    chk_reset_outputs("t6_rst");
    rst = 1'b0; bus.in_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("t6_no_done", 32'(done_cnt - mark_d), 32'd0);
    mark_w = wlog_addr.size(); mark_d = done_cnt;
    start_job(16'h0300, 16'd2);
    bus.in_valid = 1'b1; bus.in_data = 32'h77; cyc();
    bus.in_data = 32'h88; cyc();
    bus.in_valid = 1'b0;
    wait_idle(20);
    chk("t6_nwrites", 32'(wlog_addr.size() - mark_w), 32'd2);
    if (wlog_addr.size() >= mark_w + 2) begin
      chk("t6_addr0", 32'(wlog_addr[mark_w]),     32'h0300);
      chk("t6_data0", wlog_data[mark_w],          32'h77);
      chk("t6_addr1", 32'(wlog_addr[mark_w + 1]), 32'h0301);
      chk("t6_data1", wlog_data[mark_w + 1],      32'h88);
    end
    chk("t6_done_once", 32'(done_cnt - mark_d), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
